pixel_fetch_ctrl: RTL and testbench

- Sequences one video frame from frame memory into the pixel FIFO of the pixel buffer.
- Issues pixel read requests to the memory port and throttles them by credit (current FIFO level plus reads in flight).
- Forwards returned pixels to the FIFO write port and counts pixels and lines.
- Flags line end, frame end, overflow and abort.

---
 rtl/pixel_fetch_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pixel_fetch_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch_ctrl.sv
// Frame fetch sequencer: credit-throttled pixel reads from frame memory into the pixel FIFO.
// Define PIXEL_FETCH_CONTINUOUS_EN to stream frames back-to-back until stop.
module pixel_fetch_ctrl #(
  parameter int LINE_PIXELS     = 640,
  parameter int FRAME_LINES     = 480,
  parameter int ADDR_W          = 19,
  parameter int FIFO_DEPTH      = 1280,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] baseAddr,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memGnt,
  input  logic              memRdValid,
  input  logic [23:0]       memRdData,
  input  logic [10:0]       fifoLevel,
  input  logic              fifoFull,
  output logic              fifoWrEn,
  output logic [23:0]       fifoWrData,
  output logic              busy,
  output logic              lineDone,
  output logic              frameDone,
  output logic              aborted,
  output logic              overflowErr
);

  localparam int TOTAL  = LINE_PIXELS * FRAME_LINES;
  localparam int REQ_W  = $clog2(TOTAL + 1);
  localparam int PIX_W  = $clog2(LINE_PIXELS + 1);
  localparam int LINE_W = $clog2(FRAME_LINES + 1);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [REQ_W-1:0] REQ_LAST  = REQ_W'(TOTAL - 1);
  localparam logic [REQ_W-1:0] REQ_TOTAL = REQ_W'(TOTAL);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(LINE_PIXELS - 1);
  localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [11:0]      DEPTH12   = 12'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state;
  logic              abort_flag;
  logic [REQ_W-1:0]  req_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [LINE_W-1:0] line_cnt;
`ifdef PIXEL_FETCH_CONTINUOUS_EN
  logic [ADDR_W-1:0] base_lat;
`endif

  logic              grant;
  logic              rd_ok;
  logic              req_ok;
  logic [OUT_W-1:0]  out_nxt;
  logic [REQ_W-1:0]  req_nxt;
  logic [11:0]       credit_sum;

  assign grant   = memReq & memGnt;
  // A return with nothing outstanding is a protocol error and is dropped.
  assign rd_ok   = memRdValid & (out_cnt != '0);
  assign out_nxt = out_cnt + OUT_W'(grant) - OUT_W'(rd_ok);
  assign req_nxt = req_cnt + REQ_W'(grant);

  // Credit counts the request being granted now, so the registered memReq never overshoots the FIFO.
  assign credit_sum = 12'(fifoLevel) + 12'(out_cnt) + 12'(fifoWrEn) + 12'(grant);
  assign req_ok     = (credit_sum < DEPTH12) && (out_nxt < OUT_MAX) && (req_nxt < REQ_TOTAL);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      abort_flag  <= 1'b0;
      req_cnt     <= '0;
      out_cnt     <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      memReq      <= 1'b0;
      memAddr     <= '0;
      fifoWrEn    <= 1'b0;
      fifoWrData  <= '0;
      lineDone    <= 1'b0;
      frameDone   <= 1'b0;
      aborted     <= 1'b0;
      overflowErr <= 1'b0;
`ifdef PIXEL_FETCH_CONTINUOUS_EN
      base_lat    <= '0;
`endif
    end else begin
      lineDone  <= 1'b0;
      frameDone <= 1'b0;
      aborted   <= 1'b0;

      out_cnt <= out_nxt;
      if (grant) begin
        memAddr <= memAddr + 1'b1;
        req_cnt <= req_nxt;
      end

      fifoWrEn <= rd_ok;
      if (rd_ok) begin
        fifoWrData <= memRdData;
        if (pix_cnt == PIX_LAST) begin
          lineDone <= 1'b1;
          pix_cnt  <= '0;
          line_cnt <= line_cnt + 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end

      if (fifoWrEn && fifoFull) overflowErr <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            abort_flag  <= 1'b0;
            memAddr     <= baseAddr;
            req_cnt     <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            overflowErr <= 1'b0;
`ifdef PIXEL_FETCH_CONTINUOUS_EN
            base_lat    <= baseAddr;
`endif
          end
        end
        FETCH: begin
          if (stop) begin
            // A grant in this same cycle is already counted above.
            memReq     <= 1'b0;
            abort_flag <= 1'b1;
            state      <= DRAIN;
          end else if (grant && (req_cnt == REQ_LAST)) begin
            memReq <= 1'b0;
            state  <= DRAIN;
          end else if (!(memReq && !memGnt)) begin
            memReq <= req_ok;
          end
        end
        DRAIN: begin
          if ((out_cnt == '0) && !fifoWrEn) begin
            if (abort_flag) begin
              aborted <= 1'b1;
              state   <= IDLE;
            end else begin
              frameDone <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
`ifdef PIXEL_FETCH_CONTINUOUS_EN
          state    <= FETCH;
          memAddr  <= base_lat;
          req_cnt  <= '0;
          pix_cnt  <= '0;
          line_cnt <= '0;
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Scoreboard bench for pixel_fetch_ctrl: memory responder pushes expected FIFO writes, monitor pops and compares.
module tb_pixel_fetch_ctrl;

  localparam int LP = 4;
  localparam int FL = 2;
  localparam int AW = 19;
  localparam int FD = 16;
  localparam int MO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memGnt = 1'b1;
  logic          memRdValid = 1'b0;
  logic [23:0]   memRdData = '0;
  logic [10:0]   fifoLevel = '0;
  logic          fifoFull = 1'b0;
  logic          fifoWrEn;
  logic [23:0]   fifoWrData;
  logic          busy;
  logic          lineDone;
  logic          frameDone;
  logic          aborted;
  logic          overflowErr;

  pixel_fetch_ctrl #(
    .LINE_PIXELS(LP), .FRAME_LINES(FL), .ADDR_W(AW), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .baseAddr(baseAddr),
    .memReq(memReq), .memAddr(memAddr), .memGnt(memGnt),
    .memRdValid(memRdValid), .memRdData(memRdData),
    .fifoLevel(fifoLevel), .fifoFull(fifoFull),
    .fifoWrEn(fifoWrEn), .fifoWrData(fifoWrData),
    .busy(busy), .lineDone(lineDone), .frameDone(frameDone),
    .aborted(aborted), .overflowErr(overflowErr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; int ready; } pend_t;
  typedef struct { logic [23:0] dat; logic line; } exp_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int grant_cnt = 0;
  int first_gnt = 0;
  int last_gnt = 0;
  int wr_idx = 0;
  int wr_cnt = 0;
  int line_cnt = 0;
  int frame_cnt = 0;
  int abort_cnt = 0;
  logic [AW-1:0] exp_addr = '0;
  bit hold = 1'b0;
  bit expect_on = 1'b1;

  function automatic logic [23:0] pix_of(logic [AW-1:0] a);
    return {5'h15, a};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory responder: grants are sampled mid-cycle, data returns two cycles later, in order.
  initial begin
    pend_t p;
    exp_t  e;
    forever begin
      @(negedge clk);
      ncyc++;
      memRdValid = 1'b0;
      if (!hold && pend_q.size() > 0 && pend_q[0].ready <= ncyc) begin
        p = pend_q.pop_front();
        memRdValid = 1'b1;
        memRdData  = pix_of(p.addr);
        if (expect_on) begin
          e.dat  = pix_of(p.addr);
          e.line = ((wr_idx % LP) == LP - 1);
          exp_q.push_back(e);
          wr_idx++;
        end
      end
      if (memReq && memGnt) begin
        chk("req_addr", 32'(memAddr), 32'(exp_addr));
        exp_addr++;
        if (grant_cnt == 0) first_gnt = ncyc;
        last_gnt = ncyc;
        grant_cnt++;
        p.addr  = memAddr;
        p.ready = ncyc + 2;
        pend_q.push_back(p);
      end
    end
  end

  // Output monitor.
  initial begin
    bit   prev_fd;
    exp_t e;
    prev_fd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_fd) chk("busy_after_frame", 32'(busy), 0);
        if (frameDone) begin
          frame_cnt++;
          chk("busy_during_frame_done", 32'(busy), 1);
        end
        if (aborted) abort_cnt++;
        if (fifoWrEn) begin
          wr_cnt++;
          if (lineDone) line_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual data=%0h expected no write", fifoWrData);
          end else begin
            e = exp_q.pop_front();
            chk("wr_data", 32'(fifoWrData), 32'(e.dat));
            chk("line_done", 32'(lineDone), 32'(e.line));
          end
        end else begin
          chk("line_done_idle", 32'(lineDone), 0);
        end
        prev_fd = frameDone;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_start(logic [AW-1:0] base);
    grant_cnt = 0;
    exp_addr  = base;
    wr_idx    = 0;
    wr_cnt    = 0;
    line_cnt  = 0;
    frame_cnt = 0;
    abort_cnt = 0;
    baseAddr  = base;
    start     = 1'b1;
    cyc(1);
    start     = 1'b0;
  endtask

  task automatic wait_idle(int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      cyc(1);
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
    cyc(2);
  endtask

  task automatic wait_grants(int g, int max);
    int n;
    n = 0;
    while (grant_cnt < g && n < max) begin
      cyc(1);
      n++;
    end
    chk("grant_wait_timeout", grant_cnt, g);
  endtask

  initial begin
    int wc;
    #1 rst = 1'b1;
    #11;
    chk("rst_memReq", 32'(memReq), 0);
    chk("rst_memAddr", 32'(memAddr), 0);
    chk("rst_fifoWrEn", 32'(fifoWrEn), 0);
    chk("rst_fifoWrData", 32'(fifoWrData), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({lineDone, frameDone, aborted}), 0);
    chk("rst_overflowErr", 32'(overflowErr), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1);

    // Basic frame, plus a start pulse mid-frame that must be ignored.
    run_start(19'h100);
    chk("busy_after_start", 32'(busy), 1);
    cyc(3);
    baseAddr = 19'h700;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_idle(200);
    chk("basic_grants", grant_cnt, 8);
    chk("basic_back_to_back", last_gnt - first_gnt, 7);
    chk("basic_writes", wr_cnt, 8);
    chk("basic_lines", line_cnt, 2);
    chk("basic_frames", frame_cnt, 1);
    chk("basic_aborts", abort_cnt, 0);
    chk("basic_scoreboard_empty", exp_q.size(), 0);

    // Credit throttle.
    fifoLevel = 11'd14;
    hold = 1'b1;
    run_start(19'h200);
    cyc(10);
    chk("throttle_grants_l14", grant_cnt, 2);
    chk("throttle_req_l14", 32'(memReq), 0);
    chk("throttle_no_writes", wr_cnt, 0);
    fifoLevel = 11'd13;
    cyc(6);
    chk("throttle_grants_l13", grant_cnt, 3);
    chk("throttle_req_l13", 32'(memReq), 0);
    hold = 1'b0;
    fifoLevel = 11'd0;
    wait_idle(200);
    chk("throttle_grants", grant_cnt, 8);
    chk("throttle_writes", wr_cnt, 8);
    chk("throttle_lines", line_cnt, 2);
    chk("throttle_frames", frame_cnt, 1);

    // Grant stall.
    run_start(19'h300);
    wait_grants(2, 20);
    memGnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 32'(memReq), 1);
      chk("stall_addr", 32'(memAddr), 32'h302);
      cyc(1);
    end
    memGnt = 1'b1;
    wait_idle(200);
    chk("stall_grants", grant_cnt, 8);
    chk("stall_writes", wr_cnt, 8);
    chk("stall_frames", frame_cnt, 1);

    // Abort: stop coincides with the third grant, which still counts.
    run_start(19'h400);
    wait_grants(2, 20);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(1);
    chk("abort_req_dropped", 32'(memReq), 0);
    wait_idle(200);
    chk("abort_grants", grant_cnt, 3);
    chk("abort_writes", wr_cnt, 3);
    chk("abort_lines", line_cnt, 0);
    chk("abort_pulses", abort_cnt, 1);
    chk("abort_frames", frame_cnt, 0);
    chk("abort_scoreboard_empty", exp_q.size(), 0);

    // Overflow.
    fifoFull = 1'b1;
    run_start(19'h500);
    cyc(2);
    chk("ovf_before_write", 32'(overflowErr), 0);
    wait_idle(200);
    chk("ovf_set", 32'(overflowErr), 1);
    fifoFull = 1'b0;
    cyc(3);
    chk("ovf_sticky", 32'(overflowErr), 1);
    chk("ovf_frames", frame_cnt, 1);

    // Async reset with two reads in flight.
    fifoLevel = 11'd14;
    hold = 1'b1;
    run_start(19'h600);
    chk("ovf_cleared_by_start", 32'(overflowErr), 0);
    cyc(8);
    chk("rst_test_outstanding", grant_cnt, 2);
    expect_on = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_memReq", 32'(memReq), 0);
    chk("arst_memAddr", 32'(memAddr), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_fifoWrEn", 32'(fifoWrEn), 0);
    chk("arst_fifoWrData", 32'(fifoWrData), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    hold = 1'b0;
    fifoLevel = 11'd0;
    wc = wr_cnt;
    cyc(6);
    chk("late_strobes_delivered", pend_q.size(), 0);
    chk("late_strobes_no_write", wr_cnt, wc);
    chk("arst_stays_idle", 32'(busy), 0);
    expect_on = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
